dm_wb_stage: RTL
================

// Module: dm_wb_stage
// PURPOSE
//  Data-memory stage of the 32-bit MIPS pipeline, fed by the EX/DM stage register.
//  It holds a word-addressed data memory with a fixed multi-cycle access latency.
//  It stalls the upstream pipeline while a load or store is in flight and owns the DM/WB stage register.
//  The WB mux is resolved here: ALU result or load data goes to the register file.
// PARAMETERS
//  ADDR_W   8   word-index width; memory depth = 2**ADDR_W 32-bit words
//  MEM_LAT  2   extra cycles per load/store (>=1); one memory op occupies MEM_LAT+1 cycles
// PORTS
//  clk                input   1   single clock, all state on posedge
//  rst_n              input   1   asynchronous, active-low reset
//  ex_dm_alu_out      input   32  ALU result / byte address
//  ex_dm_rt_data      input   32  store data
//  ex_dm_rd_out_addr  input   5   destination register
//  ex_dm_wb_mux_ctrl  input   1   1 = writeback load data, 0 = writeback ALU result
//  ex_dm_wd_ctrl      input   1   memory write (store)
//  ex_dm_rd_ctrl      input   1   memory read (load)
//  ex_dm_w_enable     input   1   register-file write enable
//  ex_wb_inst_out     input   32  instruction word, for trace
//  dm_stall           output  1   comb.; freeze PC/IF/ID/ID-EX/EX-DM this cycle
//  dm_misalign        output  1   registered 1-cycle pulse: mem op with addr[1:0]!=0
//  dm_wb_data         output  32  writeback data
//  dm_wb_rd_addr      output  5   writeback register
//  dm_wb_w_enable     output  1   writeback enable
//  dm_wb_inst_out     output  32  instruction word in WB
// BEHAVIOUR
//  - Reset (rst_n=0, immediate):
//      - state=IDLE, cnt=0, all dm_wb_* outputs = 0, dm_misalign=0, dm_stall forced 0.
//      - Memory contents are not cleared.
//      - Reset mid-access abandons the op; a pending store is NOT written.
//  - mem_op = ex_dm_rd_ctrl | ex_dm_wd_ctrl.
//  - Word index = ex_dm_alu_out[ADDR_W+1:2]; upper address bits are ignored, so the address wraps.
//  - FSM IDLE/BUSY:
//      - IDLE, no mem_op: at the next edge DM/WB loads data (ALU result), rd_addr, w_enable, inst.
//        Latency is 1, no stall.
//      - IDLE, aligned mem_op: dm_stall=1; next edge -> BUSY with cnt=MEM_LAT-1; DM/WB loads a bubble.
//      - BUSY, cnt!=0: dm_stall=1; cnt decrements; DM/WB loads a bubble.
//      - BUSY, cnt==0: dm_stall=0. At this edge the store is written, the load data is captured,
//        DM/WB loads the real result, and the FSM returns to IDLE.
//  - Bubble = w_enable 0, rd_addr 0, data 0, inst 32'h0. WB never writes one op twice.
//  - Upstream holds all ex_dm_* inputs stable while dm_stall=1; values are sampled at the completion edge.
//  - dm_wb_data = wb_mux_ctrl ? mem[idx] : ex_dm_alu_out. Memory read is read-before-write.
//  - rd_ctrl & wd_ctrl together: store is performed; load data returns the pre-store word.
//  - Misaligned mem_op in IDLE:
//      - no access, no stall, no state change.
//      - DM/WB loads the op with w_enable forced 0.
//      - dm_misalign=1 for exactly the following cycle.
//  - wb_mux_ctrl=1 without rd_ctrl: the word is still read; this is not an error.
//  - Back-to-back mem ops: each takes MEM_LAT+1 cycles, no gap cycle between them.
// TESTING
//  - ALU op alu_out=0x1234, rd=5, w_en=1, mux=0 -> next cycle dm_wb_data=0x1234, rd 5, w_en 1; dm_stall never 1.
//  - MEM_LAT=2, store 0xDEADBEEF to 0x10 then load 0x10 into r8:
//      - dm_stall=1,1,0 for each op.
//      - Load completion gives dm_wb_data=0xDEADBEEF, rd 8, w_en 1.
//      - WB sees bubbles during the stall cycles.
//  - Load at 0x13 -> no stall, dm_misalign pulses 1 cycle, dm_wb_w_enable=0; memory unchanged.
//  - Wrap: with ADDR_W=8, store 0x5 to 0x400, load from 0x0 -> 0x5.
//  - rst_n low during BUSY of store 0xAA to 0x20:
//      - all outputs 0 immediately; IDLE after release.
//      - mem[0x20] keeps its old value.
//  - rd&wd at 0x30 (old 0x1, rt 0x2, mux=1) -> dm_wb_data=0x1; a later load of 0x30 gives 0x2.

Source files
------------

// File: rtl/dm_wb_stage_if.sv
// rtl/dm_wb_stage_if.sv - EX/DM inputs and DM/WB outputs of the data-memory stage
// Purpose: groups the EX/DM stage-register fields, the stall/misalign flags and
//          the DM/WB stage-register fields into one bundle.
// Ports (signals):
//   ex_dm_alu_out/rt_data/rd_out_addr/wb_mux_ctrl/wd_ctrl/rd_ctrl/w_enable,
//   ex_wb_inst_out       : EX/DM register contents, driven by the pipeline (master)
//   dm_stall, dm_misalign: stage status back to the pipeline
//   dm_wb_data/rd_addr/w_enable/inst_out : DM/WB register contents
interface dm_wb_stage_if;
  logic [31:0] ex_dm_alu_out;
  logic [31:0] ex_dm_rt_data;
  logic [4:0]  ex_dm_rd_out_addr;
  logic        ex_dm_wb_mux_ctrl;
  logic        ex_dm_wd_ctrl;
  logic        ex_dm_rd_ctrl;
  logic        ex_dm_w_enable;
  logic [31:0] ex_wb_inst_out;
  logic        dm_stall;
  logic        dm_misalign;
  logic [31:0] dm_wb_data;
  logic [4:0]  dm_wb_rd_addr;
  logic        dm_wb_w_enable;
  logic [31:0] dm_wb_inst_out;

  modport master (
    output ex_dm_alu_out, ex_dm_rt_data, ex_dm_rd_out_addr, ex_dm_wb_mux_ctrl,
           ex_dm_wd_ctrl, ex_dm_rd_ctrl, ex_dm_w_enable, ex_wb_inst_out,
    input  dm_stall, dm_misalign, dm_wb_data, dm_wb_rd_addr, dm_wb_w_enable,
           dm_wb_inst_out
  );

  modport slave (
    input  ex_dm_alu_out, ex_dm_rt_data, ex_dm_rd_out_addr, ex_dm_wb_mux_ctrl,
           ex_dm_wd_ctrl, ex_dm_rd_ctrl, ex_dm_w_enable, ex_wb_inst_out,
    output dm_stall, dm_misalign, dm_wb_data, dm_wb_rd_addr, dm_wb_w_enable,
           dm_wb_inst_out
  );
endinterface

// File: rtl/dm_wb_stage.sv
// rtl/dm_wb_stage.sv - MIPS data-memory stage with multi-cycle memory and DM/WB register
// Purpose: word-addressed data memory with MEM_LAT extra cycles per access, upstream
//          stall generation, writeback mux and the DM/WB stage register.
// Ports:
//   clk   : clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : dm_wb_stage_if.slave (EX/DM fields in; stall, misalign, DM/WB fields out)
module dm_wb_stage #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  dm_wb_stage_if.slave  bus
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [31:0]       mem [DEPTH];

  logic              mem_op;
  logic              misaligned;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rdata;
  logic [31:0]       result;
  logic              stall_c;
  logic              mem_we;
  logic              misalign_next;

  logic [31:0]       wb_data_q, wb_data_next;
  logic [4:0]        wb_rd_q, wb_rd_next;
  logic              wb_we_q, wb_we_next;
  logic [31:0]       wb_inst_q, wb_inst_next;
  logic              misalign_q;

  assign mem_op     = bus.ex_dm_rd_ctrl | bus.ex_dm_wd_ctrl;
  assign misaligned = |bus.ex_dm_alu_out[1:0];
  // Upper address bits are dropped, so addresses wrap around the memory.
  assign idx        = bus.ex_dm_alu_out[ADDR_W+1:2];
  // Combinational read sees the word before any store at this edge lands.
  assign rdata      = mem[idx];
  assign result     = bus.ex_dm_wb_mux_ctrl ? rdata : bus.ex_dm_alu_out;

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    stall_c       = 1'b0;
    mem_we        = 1'b0;
    misalign_next = 1'b0;
    // Bubble by default
    wb_data_next  = 32'h0;
    wb_rd_next    = 5'd0;
    wb_we_next    = 1'b0;
    wb_inst_next  = 32'h0;
    case (state)
      IDLE: begin
        if (mem_op && misaligned) begin
          // Pass the op through without touching memory and without a register write.
          wb_data_next  = result;
          wb_rd_next    = bus.ex_dm_rd_out_addr;
          wb_inst_next  = bus.ex_wb_inst_out;
          misalign_next = 1'b1;
        end else if (mem_op) begin
          stall_c    = 1'b1;
          state_next = BUSY;
          cnt_next   = CNT_W'(MEM_LAT - 1);
        end else begin
          wb_data_next = result;
          wb_rd_next   = bus.ex_dm_rd_out_addr;
          wb_we_next   = bus.ex_dm_w_enable;
          wb_inst_next = bus.ex_wb_inst_out;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          stall_c  = 1'b1;
          cnt_next = cnt - CNT_W'(1);
        end else begin
          mem_we       = bus.ex_dm_wd_ctrl;
          wb_data_next = result;
          wb_rd_next   = bus.ex_dm_rd_out_addr;
          wb_we_next   = bus.ex_dm_w_enable;
          wb_inst_next = bus.ex_wb_inst_out;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      wb_data_q  <= 32'h0;
      wb_rd_q    <= 5'd0;
      wb_we_q    <= 1'b0;
      wb_inst_q  <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      wb_data_q  <= wb_data_next;
      wb_rd_q    <= wb_rd_next;
      wb_we_q    <= wb_we_next;
      wb_inst_q  <= wb_inst_next;
      misalign_q <= misalign_next;
    end
  end

  // Memory contents survive reset; a store only lands from BUSY, which reset leaves.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= bus.ex_dm_rt_data;
    end
  end

  assign bus.dm_stall       = stall_c & rst_n;
  assign bus.dm_misalign    = misalign_q;
  assign bus.dm_wb_data     = wb_data_q;
  assign bus.dm_wb_rd_addr  = wb_rd_q;
  assign bus.dm_wb_w_enable = wb_we_q;
  assign bus.dm_wb_inst_out = wb_inst_q;

endmodule
